// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, controller opcodes, FSM encodings.
package ifetch_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int INSTR_W    = 8;

    // Opcode nibble (instr[7:4]) values decoded by the sequencing controller
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_OUT  = 4'h2;
    localparam logic [3:0] OP_WAIT = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JNZ  = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] b);
        return b[7:4];
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch unit bus: program-memory req/ack port, controller valid/ready port and redirect.
interface ifetch_if #(
    parameter int ADDR_W = ifetch_pkg::ADDR_W_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [7:0]        instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] pc;

    modport master (
        output mem_req, mem_addr, instr, instr_valid, pc,
        input  mem_ack, mem_data, instr_ready, jump, jump_addr
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, pc,
        output mem_ack, mem_data, instr_ready, jump, jump_addr
    );
endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH x W synchronous FIFO with occupancy count, flush and sync reset.
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage carries no reset; only entries below count are ever observed
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: walks the PC, prefetches bytes over req/ack, serves them valid/ready.
// Build option IFETCH_BYPASS_EN: forward mem_data straight to instr when the buffer is empty.
//
// state      | meaning
// ST_IDLE    | nothing outstanding; issue a request when the buffer has room
// ST_REQ     | request outstanding; returned byte is kept
// ST_DISCARD | request outstanding across a jump; returned byte is dropped
module ifetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic      clk,
    input logic      rst,
    ifetch_if.master bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t              state;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   fptr;
    logic [ADDR_W-1:0]   pc_q;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_after;
    logic [INSTR_W-1:0]  head;
    logic                fifo_valid;
    logic                ack_live;
    logic                byp;
    logic                take;
    logic                pop;
    logic                push;

    assign fifo_valid = (count != '0);
    assign ack_live   = bus.mem_ack && (state == ST_REQ) && !bus.jump;
`ifdef IFETCH_BYPASS_EN
    assign byp = ack_live && !fifo_valid;
`else
    assign byp = 1'b0;
`endif
    // A jump cancels any consume in the same cycle
    assign take        = (fifo_valid || byp) && bus.instr_ready && !bus.jump;
    assign pop         = take && fifo_valid;
    assign push        = ack_live && !(take && !fifo_valid);
    assign count_after = count + CW'(push) - CW'(pop);

    ifetch_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.mem_data),
        .pop       (pop),
        .flush     (bus.jump),
        .head      (head),
        .count     (count)
    );

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = fifo_valid || byp;
    assign bus.instr       = fifo_valid ? head : (byp ? bus.mem_data : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            req_q  <= 1'b0;
            addr_q <= RESET_PC;
            fptr   <= RESET_PC;
            pc_q   <= RESET_PC;
        end else begin
            if (bus.jump) begin
                fptr <= bus.jump_addr;
                pc_q <= bus.jump_addr;
            end else if (take) begin
                pc_q <= pc_q + ADDR_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (!bus.jump && count < DEPTH_C) begin
                        req_q  <= 1'b1;
                        addr_q <= fptr;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.jump) begin
                        if (bus.mem_ack) begin
                            req_q <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (bus.mem_ack) begin
                        fptr <= fptr + ADDR_W'(1);
                        // Chain straight into the next request if the buffer still has room
                        if (count_after < DEPTH_C) begin
                            addr_q <= fptr + ADDR_W'(1);
                        end else begin
                            req_q <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: vector table, scoreboarded streaming, jump/reset/wrap/bypass sequences.
module tb_ifetch;

`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    ifetch_if #(.ADDR_W(16)) b1 ();
    ifetch_if #(.ADDR_W(16)) b2 ();

    ifetch #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (.clk(clk), .rst(rst), .bus(b1));
    ifetch #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'hFFFF)) dut_wrap (.clk(clk), .rst(rst2), .bus(b2));

    typedef struct packed {
        logic        ack;
        logic [7:0]  data;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [7:0]  e_instr;
        logic [15:0] e_pc;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    vec_t  tbl [16];
    exp_t  q [$];
    exp_t  e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    wcnt;
    logic  a;
    logic  rdy;
    logic [7:0]  dd;
    logic [15:0] exp_addr;

    function automatic vec_t mk(input logic ack, input logic [7:0] d, input logic r,
                                input logic er, input logic [15:0] ea, input logic ev,
                                input logic [7:0] ei, input logic [15:0] ep);
        vec_t v;
        v.ack = ack; v.data = d; v.ready = r;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    function automatic logic [7:0] rom(input logic [15:0] addr);
        case (addr)
            16'h0000: return 8'h12;
            16'h0001: return 8'h34;
            16'h0002: return 8'h56;
            default:  return addr[7:0] ^ 8'hA5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic ack, input logic [7:0] data, input logic ready,
                         input logic jump, input logic [15:0] jaddr);
        if (d == 1) begin
            b1.mem_ack = ack; b1.mem_data = data; b1.instr_ready = ready;
            b1.jump = jump; b1.jump_addr = jaddr;
        end else begin
            b2.mem_ack = ack; b2.mem_data = data; b2.instr_ready = ready;
            b2.jump = jump; b2.jump_addr = jaddr;
        end
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int d, input string tag, input logic e_req, input logic [15:0] e_addr,
                              input logic e_valid, input logic [7:0] e_instr, input logic [15:0] e_pc);
        logic r, v;
        logic [15:0] ad, p;
        logic [7:0] ins;
        r   = (d == 1) ? b1.mem_req     : b2.mem_req;
        ad  = (d == 1) ? b1.mem_addr    : b2.mem_addr;
        v   = (d == 1) ? b1.instr_valid : b2.instr_valid;
        ins = (d == 1) ? b1.instr       : b2.instr;
        p   = (d == 1) ? b1.pc          : b2.pc;
        chk({tag, ".mem_req"}, 32'(r), 32'(e_req));
        if (e_req) chk({tag, ".mem_addr"}, 32'(ad), 32'(e_addr));
        chk({tag, ".instr_valid"}, 32'(v), 32'(e_valid));
        if (e_valid) chk({tag, ".instr"}, 32'(ins), 32'(e_instr));
        chk({tag, ".pc"}, 32'(p), 32'(e_pc));
    endtask

    task automatic sb_check();
        if (b1.instr_valid && b1.instr_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_extra: got instr %0h with nothing expected", b1.instr);
            end else begin
                e = q.pop_front();
                chk("stream_instr", 32'(b1.instr), 32'(e.d));
                chk("stream_pc", 32'(b1.pc), 32'(e.a));
            end
        end
    endtask

    initial begin
        // Backpressure then single pops, DEPTH=2, starting right after reset release
        tbl[0]  = mk(0, 8'h00, 0, 1, 16'h0000, 0,   8'h00, 16'h0000);
        tbl[1]  = mk(1, 8'h12, 0, 1, 16'h0000, BYP, 8'h12, 16'h0000);
        tbl[2]  = mk(0, 8'h00, 0, 1, 16'h0001, 1,   8'h12, 16'h0000);
        tbl[3]  = mk(1, 8'h34, 0, 1, 16'h0001, 1,   8'h12, 16'h0000);
        tbl[4]  = mk(0, 8'h00, 0, 0, 16'h0000, 1,   8'h12, 16'h0000);
        tbl[5]  = mk(1, 8'hEE, 0, 0, 16'h0000, 1,   8'h12, 16'h0000);
        tbl[6]  = mk(0, 8'h00, 0, 0, 16'h0000, 1,   8'h12, 16'h0000);
        tbl[7]  = mk(0, 8'h00, 1, 0, 16'h0000, 1,   8'h12, 16'h0000);
        tbl[8]  = mk(0, 8'h00, 0, 0, 16'h0000, 1,   8'h34, 16'h0001);
        tbl[9]  = mk(0, 8'h00, 0, 1, 16'h0002, 1,   8'h34, 16'h0001);
        tbl[10] = mk(1, 8'h56, 1, 1, 16'h0002, 1,   8'h34, 16'h0001);
        tbl[11] = mk(0, 8'h00, 0, 1, 16'h0003, 1,   8'h56, 16'h0002);
        tbl[12] = mk(0, 8'h00, 1, 1, 16'h0003, 1,   8'h56, 16'h0002);
        tbl[13] = mk(0, 8'h00, 0, 1, 16'h0003, 0,   8'h00, 16'h0003);
        tbl[14] = mk(1, 8'h78, 0, 1, 16'h0003, BYP, 8'h78, 16'h0003);
        tbl[15] = mk(0, 8'h00, 0, 1, 16'h0004, 1,   8'h78, 16'h0003);

        rst = 1'b1;
        rst2 = 1'b1;
        b1.mem_ack = 0; b1.mem_data = 0; b1.instr_ready = 0; b1.jump = 0; b1.jump_addr = 0;
        b2.mem_ack = 0; b2.mem_data = 0; b2.instr_ready = 0; b2.jump = 0; b2.jump_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(1, "reset", 0, 16'h0000, 0, 8'h00, 16'h0000);
        adv();

        for (int i = 0; i < 16; i++) begin
            drive(1, tbl[i].ack, tbl[i].data, tbl[i].ready, 0, 16'h0000);
            expect_out(1, $sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                       tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc);
            adv();
        end

        // Reset while a request is outstanding and an ack arrives
        rst = 1'b1;
        drive(1, 1, 8'h99, 0, 0, 16'h0000);
        adv();
        rst = 1'b0;
        drive(1, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(1, "rst_mid", 0, 16'h0000, 0, 8'h00, 16'h0000);
        adv();

        // Jump with the request to 0x0001 outstanding; its late data must vanish
        drive(1, 1, 8'h12, 0, 0, 16'h0000);
        expect_out(1, "j_ack0", 1, 16'h0000, BYP, 8'h12, 16'h0000);
        adv();
        drive(1, 0, 8'h00, 1, 1, 16'h0100);
        expect_out(1, "j_cycle", 1, 16'h0001, 1, 8'h12, 16'h0000);
        adv();
        drive(1, 0, 8'h00, 1, 0, 16'h0000);
        expect_out(1, "j_flush", 1, 16'h0001, 0, 8'h00, 16'h0100);
        adv();
        drive(1, 1, 8'hAA, 1, 0, 16'h0000);
        expect_out(1, "j_late", 1, 16'h0001, 0, 8'h00, 16'h0100);
        adv();
        drive(1, 0, 8'h00, 1, 0, 16'h0000);
        expect_out(1, "j_idle", 0, 16'h0000, 0, 8'h00, 16'h0100);
        adv();
        drive(1, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(1, "j_newreq", 1, 16'h0100, 0, 8'h00, 16'h0100);
        adv();
        drive(1, 1, 8'h5C, 0, 0, 16'h0000);
        expect_out(1, "j_newack", 1, 16'h0100, BYP, 8'h5C, 16'h0100);
        adv();
        // Jump coinciding with an ack in REQ: data dropped, back to idle
        drive(1, 1, 8'h77, 0, 1, 16'h0200);
        expect_out(1, "ja_cycle", 1, 16'h0101, 1, 8'h5C, 16'h0100);
        adv();
        drive(1, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(1, "ja_idle", 0, 16'h0000, 0, 8'h00, 16'h0200);
        adv();
        // Ack into an empty buffer with the consumer ready
        drive(1, 1, 8'h3C, 1, 0, 16'h0000);
        expect_out(1, "empty_ack", 1, 16'h0200, BYP, 8'h3C, 16'h0200);
        adv();
        drive(1, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(1, "empty_next", 1, 16'h0201, !BYP, 8'h3C, BYP ? 16'h0201 : 16'h0200);
        adv();

        // Streaming against a memory that acks one cycle after seeing req
        rst = 1'b1;
        drive(1, 0, 8'h00, 0, 0, 16'h0000);
        adv();
        rst = 1'b0;
        wcnt = 0;
        exp_addr = 16'h0000;
        for (int c = 0; c < 60; c++) begin
            a  = b1.mem_req && (wcnt == 1);
            dd = rom(b1.mem_addr);
            if (a) begin
                chk("stream_addr", 32'(b1.mem_addr), 32'(exp_addr));
                q.push_back('{a: b1.mem_addr, d: dd});
                exp_addr = exp_addr + 16'd1;
            end
            wcnt = a ? 0 : (b1.mem_req ? 1 : 0);
            rdy  = (c < 12) ? 1'b1 : 1'(($urandom_range(0, 1)));
            drive(1, a, dd, rdy, 0, 16'h0000);
            sb_check();
            adv();
        end
        for (int c = 0; c < 8; c++) begin
            drive(1, 0, 8'h00, 1, 0, 16'h0000);
            sb_check();
            adv();
        end
        chk("stream_drain", 32'(q.size()), 32'd0);
        chk("stream_count", 32'(exp_addr >= 16'd20), 32'd1);

        // Address wrap from RESET_PC=0xFFFF
        rst2 = 1'b0;
        drive(2, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(2, "wrap_rst", 0, 16'h0000, 0, 8'h00, 16'hFFFF);
        adv();
        drive(2, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(2, "wrap_req0", 1, 16'hFFFF, 0, 8'h00, 16'hFFFF);
        adv();
        drive(2, 1, 8'h11, 0, 0, 16'h0000);
        expect_out(2, "wrap_ack0", 1, 16'hFFFF, BYP, 8'h11, 16'hFFFF);
        adv();
        drive(2, 1, 8'h22, 1, 0, 16'h0000);
        expect_out(2, "wrap_req1", 1, 16'h0000, 1, 8'h11, 16'hFFFF);
        adv();
        drive(2, 0, 8'h00, 0, 0, 16'h0000);
        expect_out(2, "wrap_pc", 1, 16'h0001, 1, 8'h22, 16'h0000);
        adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
